flash_boot_loader: RTL and testbench
====================================

// Module: flash_boot_loader
// PURPOSE
//   Program-memory front end that sits upstream of the 8-bit core: receives a framed byte stream
//   (serial bridge/host), assembles 16-bit instruction words into a 4096x16 instruction RAM,
//   verifies an XOR checksum, then serves flash_data to the core addressed by its pc_out.
//   core_hold keeps the core stalled until a valid image has been loaded.
// PARAMETERS
//   ADDR_WIDTH  12      instruction address width (depth = 2**ADDR_WIDTH words)
//   DATA_WIDTH  16      instruction word width (fixed: two bytes, high first)
//   SYNC_BYTE   8'hA5   frame start marker
// PORTS
//   clk          in   1   single system clock, all logic rising-edge
//   arst_n       in   1   reset, synchronous, active-low
//   rx_data      in   8   incoming byte
//   rx_valid     in   1   rx_data valid this cycle
//   rx_ready     out  1   loader accepts byte; transfer when rx_valid & rx_ready
//   pc_addr      in   12  core fetch address (core pc_out)
//   flash_data   out  16  instruction word to core, registered
//   core_hold    out  1   1 = core must stay stalled/bootstrapping
//   boot_done    out  1   1 = image loaded and checksum good
//   load_error   out  1   1 = last frame rejected
//   word_count   out  12  words written in current/last frame (mod 4096)
// BEHAVIOUR
//   Reset (arst_n=0 at clk edge): state=IDLE, rx_ready=1, flash_data=0, core_hold=1,
//     boot_done=0, load_error=0, word_count=0, wr_addr=0, checksum=0. RAM contents not cleared.
//   Frame: SYNC, LEN_H (bits[3:0] used), LEN_L, N=LEN+1 words (1..4096) as HI,LO bytes, CHK.
//     CHK must equal XOR of LEN_H, LEN_L and every data byte.
//   FSM (advances only on accepted byte):
//     IDLE   : byte==SYNC -> LEN_H (clear checksum, wr_addr, word_count, load_error); else drop.
//     LEN_H  : LEN_H[7:4]!=0 -> ERROR; else store, -> LEN_L.
//     LEN_L  : store, remaining=LEN, -> DATA_H.
//     DATA_H : latch hi byte -> DATA_L.
//     DATA_L : write RAM[wr_addr] <= {hi,byte} same edge; wr_addr++, word_count++;
//              remaining==0 -> CHECK, else remaining--, -> DATA_H.
//     CHECK  : byte==checksum -> DONE; else -> ERROR.
//     DONE   : rx_ready=0, core_hold=0, boot_done=1; stays until reset.
//     ERROR  : load_error=1, core_hold=1, rx_ready=1; SYNC byte restarts frame (-> LEN_H).
//   Checksum register XORs every accepted byte from LEN_H through last data byte.
//   Read port: flash_data <= RAM[pc_addr] each clk while boot_done=1 (1-cycle latency);
//     forced to 16'h0000 while boot_done=0.
//   Boundaries: LEN=0xFFF writes all 4096 words, wr_addr wraps 4095->0 on last write only;
//     rx_valid gaps stall the FSM with no state change; SYNC value inside a frame is data;
//     reset mid-frame returns to IDLE, partial RAM data left but boot_done=0.
//   No combinational path rx_valid->rx_ready; rx_ready depends on state only.
// TESTING
//   T1 reset, send A5 00 02 12 34 56 78 9A BC CHK=0x02^12^34^56^78^9A^BC -> boot_done=1,
//      core_hold=0, word_count=3; pc_addr=1 -> flash_data=16'h5678 one cycle later.
//   T2 same frame with CHK off by 1 -> load_error=1, boot_done=0, flash_data=0; then valid
//      frame -> load_error=0, boot_done=1.
//   T3 bytes 00 FF 13 before A5 frame, rx_valid toggling every other cycle -> garbage ignored,
//      load identical to T1.
//   T4 LEN_H=0x10 -> ERROR immediately, no RAM write, word_count=0.
//   T5 LEN=0xFFF, word i = i -> word_count=0 (wrapped), boot_done=1, RAM[4095]=16'h0FFF.
//   T6 reset asserted after 2 data words -> all outputs at reset values next cycle; new
//      frame loads normally.

Source files
------------

// File: rtl/flash_boot_loader_if.sv
// flash_boot_loader_if: byte-stream intake and instruction-fetch port of the boot loader
interface flash_boot_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] pc_addr;
    logic [DATA_WIDTH-1:0] flash_data;

    modport master (output rx_data, rx_valid, pc_addr, input rx_ready, flash_data);
    modport slave  (input rx_data, rx_valid, pc_addr, output rx_ready, flash_data);
endinterface

// File: rtl/flash_boot_loader.sv
// flash_boot_loader: loads a framed, XOR-checked byte stream into instruction RAM and serves it to the core
module flash_boot_loader #(
    parameter int         ADDR_WIDTH = 12,
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  arst_n,
    flash_boot_loader_if.slave    bus,
    output logic                  core_hold,
    output logic                  boot_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH-1:0] word_count
);
    typedef enum logic [2:0] {S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CHECK, S_DONE, S_ERROR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] word_count_q, word_count_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [3:0]            len_h_q, len_h_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            chk_q, chk_d;
    logic [DATA_WIDTH-1:0] flash_q;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic                  accept, we;

    // Status flags are pure state decodes, so rx_ready never sees rx_valid
    assign bus.rx_ready  = state_q != S_DONE;
    assign boot_done     = state_q == S_DONE;
    assign core_hold     = state_q != S_DONE;
    assign load_error    = state_q == S_ERROR;
    assign word_count    = word_count_q;
    assign bus.flash_data = flash_q;
    assign accept        = bus.rx_valid & bus.rx_ready;

    // Frame parser: advances one step per accepted byte
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        word_count_d = word_count_q;
        remaining_d  = remaining_q;
        len_h_d      = len_h_q;
        hi_d         = hi_q;
        chk_d        = chk_q;
        we           = 1'b0;
        if (accept) begin
            case (state_q)
                S_IDLE, S_ERROR: if (bus.rx_data == SYNC_BYTE) begin
                    state_d      = S_LEN_H;
                    chk_d        = '0;
                    wr_addr_d    = '0;
                    word_count_d = '0;
                end
                S_LEN_H: begin
                    state_d = (bus.rx_data[7:4] != 4'h0) ? S_ERROR : S_LEN_L;
                    len_h_d = bus.rx_data[3:0];
                    chk_d   = chk_q ^ bus.rx_data;
                end
                S_LEN_L: begin
                    state_d     = S_DATA_H;
                    remaining_d = ADDR_WIDTH'({len_h_q, bus.rx_data});
                    chk_d       = chk_q ^ bus.rx_data;
                end
                S_DATA_H: begin
                    state_d = S_DATA_L;
                    hi_d    = bus.rx_data;
                    chk_d   = chk_q ^ bus.rx_data;
                end
                S_DATA_L: begin
                    we           = 1'b1;
                    wr_addr_d    = wr_addr_q + 1'b1;
                    word_count_d = word_count_q + 1'b1;
                    chk_d        = chk_q ^ bus.rx_data;
                    state_d      = (remaining_q == '0) ? S_CHECK : S_DATA_H;
                    remaining_d  = (remaining_q == '0) ? remaining_q : remaining_q - 1'b1;
                end
                S_CHECK: state_d = (bus.rx_data == chk_q) ? S_DONE : S_ERROR;
                default: ;
            endcase
        end
    end

    // Parser state registers
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            wr_addr_q    <= '0;
            word_count_q <= '0;
            remaining_q  <= '0;
            len_h_q      <= '0;
            hi_q         <= '0;
            chk_q        <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            word_count_q <= word_count_d;
            remaining_q  <= remaining_d;
            len_h_q      <= len_h_d;
            hi_q         <= hi_d;
            chk_q        <= chk_d;
        end
    end

    // Instruction RAM write; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr_q] <= {hi_q, bus.rx_data};
    end

    // Registered fetch port, held at zero until a good image is loaded
    always_ff @(posedge clk) begin
        if (!arst_n) flash_q <= '0;
        else         flash_q <= boot_done ? mem[bus.pc_addr] : '0;
    end
endmodule

// File: tb/tb_flash_boot_loader.sv
// tb_flash_boot_loader: self-checking bench for the flash boot loader
module tb_flash_boot_loader;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        core_hold, boot_done, load_error;
    logic [11:0] word_count;
    int          total = 0;
    int          bad = 0;
    logic [15:0] img [4096];
    logic [15:0] exp_q [$];

    typedef struct {
        logic [11:0] addr;
        logic [15:0] exp;
    } vec_t;

    flash_boot_loader_if bus ();

    flash_boot_loader dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .bus        (bus.slave),
        .core_hold  (core_hold),
        .boot_done  (boot_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout: got 0 expected 1");
        end
        @(negedge clk);
        if (gap) begin
            bus.rx_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [11:0] len, input logic [7:0] chk_err, input bit gap);
        logic [7:0] c;
        c = {4'h0, len[11:8]} ^ len[7:0];
        send_byte(8'hA5, gap);
        send_byte({4'h0, len[11:8]}, gap);
        send_byte(len[7:0], gap);
        for (int i = 0; i <= int'(len); i++) begin
            send_byte(img[i][15:8], gap);
            send_byte(img[i][7:0], gap);
            c = c ^ img[i][15:8] ^ img[i][7:0];
        end
        send_byte(c ^ chk_err, gap);
        bus.rx_valid = 1'b0;
    endtask

    task automatic rd(input logic [11:0] addr, input logic [15:0] exp);
        bus.pc_addr = addr;
        exp_q.push_back(exp);
        @(negedge clk);
        chk("flash_data", bus.flash_data, exp_q.pop_front());
    endtask

    task automatic status(input string tag, input logic hold, input logic done, input logic err, input logic [11:0] wc);
        chk({tag, "_core_hold"}, core_hold, hold);
        chk({tag, "_boot_done"}, boot_done, done);
        chk({tag, "_load_error"}, load_error, err);
        chk({tag, "_word_count"}, word_count, wc);
    endtask

    initial begin
        vec_t t1v [3];
        t1v[0] = '{12'd0, 16'h1234};
        t1v[1] = '{12'd1, 16'h5678};
        t1v[2] = '{12'd2, 16'h9ABC};
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.pc_addr  = 12'd0;

        // T1: reset values, then a 3-word image
        do_reset();
        status("rst", 1'b1, 1'b0, 1'b0, 12'd0);
        chk("rst_rx_ready", bus.rx_ready, 1'b1);
        chk("rst_flash_data", bus.flash_data, 16'h0000);
        img[0] = 16'h1234; img[1] = 16'h5678; img[2] = 16'h9ABC;
        send_frame(12'd2, 8'h00, 1'b0);
        status("t1", 1'b0, 1'b1, 1'b0, 12'd3);
        chk("t1_rx_ready", bus.rx_ready, 1'b0);
        for (int i = 0; i < 3; i++) rd(t1v[i].addr, t1v[i].exp);

        // T2: bad checksum, then recovery with a different image
        do_reset();
        send_frame(12'd2, 8'h01, 1'b0);
        status("t2_bad", 1'b1, 1'b0, 1'b1, 12'd3);
        chk("t2_rx_ready", bus.rx_ready, 1'b1);
        rd(12'd1, 16'h0000);
        img[0] = 16'h1111; img[1] = 16'h2222;
        send_frame(12'd1, 8'h00, 1'b0);
        status("t2_ok", 1'b0, 1'b1, 1'b0, 12'd2);
        rd(12'd1, 16'h2222);

        // T3: leading garbage and rx_valid gaps
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h13, 1'b1);
        chk("t3_garbage_wc", word_count, 12'd0);
        img[0] = 16'h1234; img[1] = 16'h5678; img[2] = 16'h9ABC;
        send_frame(12'd2, 8'h00, 1'b1);
        status("t3", 1'b0, 1'b1, 1'b0, 12'd3);
        for (int i = 0; i < 3; i++) rd(t1v[i].addr, t1v[i].exp);

        // T4: oversize LEN_H rejected, then minimal single-word frame
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        bus.rx_valid = 1'b0;
        status("t4_err", 1'b1, 1'b0, 1'b1, 12'd0);
        img[0] = 16'hBEEF;
        send_frame(12'd0, 8'h00, 1'b0);
        status("t4_ok", 1'b0, 1'b1, 1'b0, 12'd1);
        rd(12'd0, 16'hBEEF);
        rd(12'd1, 16'h5678);

        // T5: full 4096-word image, word_count wraps
        do_reset();
        for (int i = 0; i < 4096; i++) img[i] = 16'(i);
        send_frame(12'hFFF, 8'h00, 1'b0);
        status("t5", 1'b0, 1'b1, 1'b0, 12'd0);
        rd(12'd4095, 16'h0FFF);
        rd(12'd0, 16'h0000);
        rd(12'd2048, 16'h0800);
        rd(12'd3, 16'h0003);

        // T6: reset mid-frame, then reload including SYNC values as data
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hCA, 1'b0);
        send_byte(8'hFE, 1'b0);
        chk("t6_mid_wc", word_count, 12'd2);
        do_reset();
        status("t6_rst", 1'b1, 1'b0, 1'b0, 12'd0);
        chk("t6_rx_ready", bus.rx_ready, 1'b1);
        chk("t6_flash_data", bus.flash_data, 16'h0000);
        img[0] = 16'hA5A5; img[1] = 16'h00A5;
        send_frame(12'd1, 8'h00, 1'b0);
        status("t6_ok", 1'b0, 1'b1, 1'b0, 12'd2);
        rd(12'd0, 16'hA5A5);
        rd(12'd1, 16'h00A5);
        rd(12'd2, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
